i2c_poll_sequencer: RTL and testbench
=====================================

Name: i2c_poll_sequencer

Overview:
- Upstream command sequencer for the i2c bus master: walks a table of NUM_CMDS transaction slots, drives the master's start/addr/rw/stop/bytes/data inputs, waits out each transaction and latches data_in/error into per-slot result registers.
- Repeats the table every PERIOD clk cycles, so the host sees continuously refreshed sensor words without touching bus timing.

Parameters:
- NUM_CMDS, 4, number of table slots (1..16).
- MAX_BITS, 64, write-data width per slot; matches the master.
- MAX_DIN, 64, read-data width per slot; matches the master.
- PERIOD, 1000000, clk cycles between table-pass starts; must be at least 1.
- GAP, 100, idle clk cycles between consecutive slots.
- TIMEOUT, 100000, clk cycles allowed for master busy to rise after start.

Ports:
- clk  in  1  system clock; same clock that feeds the master.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run polling; when 0, the block finishes the current slot, then idles.
- do_wakeup  in  1  issue one wakeup before the first pass after reset.
- cmd_en  in  NUM_CMDS  per-slot enable.
- cmd_addr  in  7*NUM_CMDS  per-slot 7-bit address; slot i is at [7i+6:7i].
- cmd_rw  in  NUM_CMDS  per-slot rw (0 = write, 1 = read).
- cmd_stop  in  NUM_CMDS  per-slot stop flag.
- cmd_bytes  in  5*NUM_CMDS  per-slot byte count.
- cmd_data  in  MAX_BITS*NUM_CMDS  per-slot write data, MSB-first.
- m_start  out  1  to master start.
- m_wakeup  out  1  to master wakeup.
- m_addr  out  7  to master set_addr.
- m_rw  out  1  to master set_rw.
- m_stop  out  1  to master stop.
- m_bytes  out  5  to master set_bytes.
- m_data_out  out  MAX_BITS  to master set_data_out.
- m_busy  in  1  from master busy.
- m_data_in  in  MAX_DIN  from master data_in.
- m_error  in  1  from master error.
- result  out  MAX_DIN*NUM_CMDS  latched read data per slot.
- result_valid  out  NUM_CMDS  per-slot result updated since the last pass start.
- slot_error  out  NUM_CMDS  per-slot NACK or timeout seen on the last attempt.
- pass_done  out  1  one-cycle pulse when a table pass completes.
- timeout_cnt  out  16  saturating count of start timeouts.

Behaviour:
- Reset values:
  - All outputs are 0, including m_start and m_wakeup.
  - State is IDLE. The period counter is loaded with 0, so the first pass starts immediately once enable=1.
  - The wakeup-pending flag is set from do_wakeup when reset releases.
- States: IDLE, WAKE, WAKE_RUN, SELECT, ISSUE, RUN, CAPTURE, GAP.
- IDLE:
  - The period counter decrements each cycle and saturates at 0.
  - Exit requires enable=1, counter=0 and m_busy=0. On exit, reload the counter with PERIOD-1, clear result_valid, and set slot index to 0.
  - Go to WAKE if wakeup is pending, else SELECT.
- WAKE: assert m_wakeup until m_busy=1, then drop it and go to WAKE_RUN.
- WAKE_RUN: wait for m_busy=0, clear the wakeup-pending flag, go to SELECT.
- SELECT:
  - One cycle per slot examined.
  - If cmd_en[idx]=0, increment idx.
  - If idx reaches NUM_CMDS, pulse pass_done and go to IDLE.
  - Otherwise register the slot fields onto m_* and go to ISSUE.
- ISSUE:
  - Hold m_start=1 and the m_* fields stable until m_busy=1. The master samples on its slow bus clock, so start must persist.
  - On m_busy=1: drop m_start, go to RUN.
  - If TIMEOUT cycles elapse without busy: drop m_start, set slot_error[idx], increment timeout_cnt (saturating at 0xFFFF), go to GAP.
- RUN: wait for m_busy=0, then go to CAPTURE. The m_* fields stay stable throughout RUN.
- CAPTURE (one cycle):
  - slot_error[idx] <= m_error.
  - If m_rw=1 and m_error=0: result slice idx <= m_data_in and result_valid[idx] <= 1.
  - On error the previous result is retained.
  - Write slots never set result_valid.
  - Go to GAP.
- GAP:
  - Count GAP cycles, increment idx, then go to SELECT.
  - If enable=0 at the end of GAP, go to IDLE instead; no pass_done is issued.
- Cadence: if a pass takes longer than PERIOD, the next pass starts as soon as IDLE is entered, because the counter has already reached 0. There is no backlog accumulation.
- Mid-pass changes: cmd_* changes are picked up only at SELECT; a slot in flight is unaffected.
- Reset mid-transaction: all state clears and m_start drops immediately. The master is expected to recover through its own bus-free handling.
- If no slot is enabled, a pass is NUM_CMDS SELECT cycles followed by a pass_done pulse.

Test Plan:
1. NUM_CMDS=2, both read slots, master model returns 0xA5 and 0x3C with busy 40 cycles -> result slices 0xA5 and 0x3C, result_valid=2'b11, one pass_done pulse per pass.
2. Slot 0 read, model asserts m_error=1 -> slot_error[0]=1, result slice 0 unchanged, result_valid[0]=0; slot 1 still executes.
3. Model never raises busy, TIMEOUT=50 -> m_start falls 50 cycles after rising, timeout_cnt=1, slot_error set, sequencer advances.
4. do_wakeup=1 at reset -> exactly one m_wakeup handshake precedes the first m_start, and none occur on later passes.
5. PERIOD=500 with a short pass -> pass starts spaced exactly 500 cycles apart. Then drop enable mid-slot -> the slot completes, the block returns to IDLE and no pass_done is issued.
6. Assert rst_n=0 during RUN -> all outputs are 0 on the same cycle, and a clean restart follows when rst_n=1.

Source files
------------

// File: rtl/i2c_poll_sequencer.sv
// i2c_poll_sequencer: walks a table of NUM_CMDS transaction slots, drives
// them one at a time into the i2c bus master, waits each one out and
// latches read data / error status per slot. Passes repeat every PERIOD
// clk cycles.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   enable            run polling (current slot always finishes)
//   do_wakeup         one wakeup handshake before the first pass
//   cmd_*             per-slot table (en, addr, rw, stop, bytes, data)
//   m_*  (out)        start/wakeup/addr/rw/stop/bytes/data_out to master
//   m_busy, m_data_in, m_error   status from master
//   result            per-slot latched read data
//   result_valid      per-slot result refreshed since the last pass start
//   slot_error        per-slot NACK/timeout on the last attempt
//   pass_done         one-cycle pulse at the end of a full pass
//   timeout_cnt       saturating count of start timeouts
module i2c_poll_sequencer #(
  parameter int unsigned NUM_CMDS = 4,
  parameter int unsigned MAX_BITS = 64,
  parameter int unsigned MAX_DIN  = 64,
  parameter int unsigned PERIOD   = 1000000,
  parameter int unsigned GAP      = 100,
  parameter int unsigned TIMEOUT  = 100000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         do_wakeup,
  input  logic [NUM_CMDS-1:0]          cmd_en,
  input  logic [7*NUM_CMDS-1:0]        cmd_addr,
  input  logic [NUM_CMDS-1:0]          cmd_rw,
  input  logic [NUM_CMDS-1:0]          cmd_stop,
  input  logic [5*NUM_CMDS-1:0]        cmd_bytes,
  input  logic [MAX_BITS*NUM_CMDS-1:0] cmd_data,
  output logic                         m_start,
  output logic                         m_wakeup,
  output logic [6:0]                   m_addr,
  output logic                         m_rw,
  output logic                         m_stop,
  output logic [4:0]                   m_bytes,
  output logic [MAX_BITS-1:0]          m_data_out,
  input  logic                         m_busy,
  input  logic [MAX_DIN-1:0]           m_data_in,
  input  logic                         m_error,
  output logic [MAX_DIN*NUM_CMDS-1:0]  result,
  output logic [NUM_CMDS-1:0]          result_valid,
  output logic [NUM_CMDS-1:0]          slot_error,
  output logic                         pass_done,
  output logic [15:0]                  timeout_cnt
);

  localparam int unsigned IDX_W    = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
  localparam int unsigned PER_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int unsigned CNT_MAX  = (GAP_LAST > TMO_LAST) ? GAP_LAST : TMO_LAST;
  localparam int unsigned CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAKE, S_WAKE_RUN, S_SELECT, S_ISSUE, S_RUN, S_CAPTURE, S_GAP
  } state_e;

  // Transaction fields presented to the master
  typedef struct packed {
    logic [6:0]          addr;
    logic                rw;
    logic                stop;
    logic [4:0]          bytes;
    logic [MAX_BITS-1:0] data;
  } cmd_t;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [PER_W-1:0]            per_q, per_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        init_q;
  logic                        wake_pend_q, wake_pend_d;
  logic                        start_q, start_d;
  logic                        wakeup_q, wakeup_d;
  cmd_t                        cmd_q, cmd_d;
  logic [MAX_DIN*NUM_CMDS-1:0] result_q, result_d;
  logic [NUM_CMDS-1:0]         valid_q, valid_d;
  logic [NUM_CMDS-1:0]         err_q, err_d;
  logic                        pass_done_q, pass_done_d;
  logic [15:0]                 tmo_q, tmo_d;
  logic [31:0]                 sel_c;

  assign sel_c = 32'(idx_q);
  wire last_slot_c = (idx_q == IDX_W'(NUM_CMDS - 1));

  assign m_start      = start_q;
  assign m_wakeup     = wakeup_q;
  assign m_addr       = cmd_q.addr;
  assign m_rw         = cmd_q.rw;
  assign m_stop       = cmd_q.stop;
  assign m_bytes      = cmd_q.bytes;
  assign m_data_out   = cmd_q.data;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign slot_error   = err_q;
  assign pass_done    = pass_done_q;
  assign timeout_cnt  = tmo_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      per_q       <= '0;
      cnt_q       <= '0;
      init_q      <= 1'b0;
      wake_pend_q <= 1'b0;
      start_q     <= 1'b0;
      wakeup_q    <= 1'b0;
      cmd_q       <= '0;
      result_q    <= '0;
      valid_q     <= '0;
      err_q       <= '0;
      pass_done_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      per_q       <= per_d;
      cnt_q       <= cnt_d;
      init_q      <= 1'b1;
      wake_pend_q <= wake_pend_d;
      start_q     <= start_d;
      wakeup_q    <= wakeup_d;
      cmd_q       <= cmd_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      pass_done_q <= pass_done_d;
      tmo_q       <= tmo_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    per_d       = (per_q != '0) ? per_q - PER_W'(1) : per_q;
    cnt_d       = cnt_q;
    // First cycle after reset samples do_wakeup into the pending flag
    wake_pend_d = init_q ? wake_pend_q : do_wakeup;
    start_d     = start_q;
    wakeup_d    = wakeup_q;
    cmd_d       = cmd_q;
    result_d    = result_q;
    valid_d     = valid_q;
    err_d       = err_q;
    pass_done_d = 1'b0;
    tmo_d       = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (enable && (per_q == '0) && !m_busy) begin
          per_d   = PER_W'(PERIOD - 1);
          valid_d = '0;
          idx_d   = '0;
          if (wake_pend_d) begin
            wakeup_d = 1'b1;
            state_d  = S_WAKE;
          end else begin
            state_d  = S_SELECT;
          end
        end
      end
      S_WAKE: begin
        if (m_busy) begin
          wakeup_d = 1'b0;
          state_d  = S_WAKE_RUN;
        end
      end
      S_WAKE_RUN: begin
        if (!m_busy) begin
          wake_pend_d = 1'b0;
          state_d     = S_SELECT;
        end
      end
      S_SELECT: begin
        if (cmd_en[idx_q]) begin
          cmd_d.addr  = cmd_addr[sel_c*7 +: 7];
          cmd_d.rw    = cmd_rw[idx_q];
          cmd_d.stop  = cmd_stop[idx_q];
          cmd_d.bytes = cmd_bytes[sel_c*5 +: 5];
          cmd_d.data  = cmd_data[sel_c*MAX_BITS +: MAX_BITS];
          start_d     = 1'b1;
          cnt_d       = '0;
          state_d     = S_ISSUE;
        end else if (last_slot_c) begin
          pass_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_ISSUE: begin
        // Start is held until the master acknowledges on its slow clock
        if (m_busy) begin
          start_d = 1'b0;
          state_d = S_RUN;
        end else if (cnt_q == CNT_W'(TMO_LAST)) begin
          start_d       = 1'b0;
          err_d[idx_q]  = 1'b1;
          if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
          cnt_d         = '0;
          state_d       = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!m_busy) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        err_d[idx_q] = m_error;
        if (cmd_q.rw && !m_error) begin
          result_d[sel_c*MAX_DIN +: MAX_DIN] = m_data_in;
          valid_d[idx_q]                     = 1'b1;
        end
        cnt_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_LAST)) begin
          if (!enable) begin
            state_d = S_IDLE;
          end else if (last_slot_c) begin
            pass_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SELECT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
module tb_i2c_poll_sequencer;
  localparam int unsigned NC  = 2;
  localparam int unsigned MB  = 16;
  localparam int unsigned MD  = 16;
  localparam int unsigned PER = 500;
  localparam int unsigned GP  = 4;
  localparam int unsigned TMO = 50;

  logic             clk, rst_n, enable, do_wakeup;
  logic [NC-1:0]    cmd_en, cmd_rw, cmd_stop;
  logic [7*NC-1:0]  cmd_addr;
  logic [5*NC-1:0]  cmd_bytes;
  logic [MB*NC-1:0] cmd_data;
  logic             m_start, m_wakeup, m_rw, m_stop;
  logic [6:0]       m_addr;
  logic [4:0]       m_bytes;
  logic [MB-1:0]    m_data_out;
  logic             m_busy, m_error;
  logic [MD-1:0]    m_data_in;
  logic [MD*NC-1:0] result;
  logic [NC-1:0]    result_valid, slot_error;
  logic             pass_done;
  logic [15:0]      timeout_cnt;

  i2c_poll_sequencer #(
    .NUM_CMDS(NC), .MAX_BITS(MB), .MAX_DIN(MD),
    .PERIOD(PER), .GAP(GP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .do_wakeup(do_wakeup),
    .cmd_en(cmd_en), .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_stop(cmd_stop),
    .cmd_bytes(cmd_bytes), .cmd_data(cmd_data),
    .m_start(m_start), .m_wakeup(m_wakeup), .m_addr(m_addr), .m_rw(m_rw),
    .m_stop(m_stop), .m_bytes(m_bytes), .m_data_out(m_data_out),
    .m_busy(m_busy), .m_data_in(m_data_in), .m_error(m_error),
    .result(result), .result_valid(result_valid), .slot_error(slot_error),
    .pass_done(pass_done), .timeout_cnt(timeout_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_pass = 0;

  // Master behaviour knobs
  bit         no_busy;
  logic [7:0] err_addr;   // bit 7 set = no address NACKs
  int         busy_len;

  // Reference model state
  logic [MD-1:0] mres [NC];
  logic [NC-1:0] mval, merr;
  logic [15:0]   mtmo;

  // Observation bookkeeping
  int         cyc = 0, n_start = 0, n_wake = 0, pass_cnt = 0;
  int         first_wake_cyc = 0, first_start_cyc = 0, hi_len = 0;
  int         first_start [16];
  bit         pass_first = 1'b1, cur_valid = 1'b0;
  bit         start_prev = 1'b0, wake_prev = 1'b0, pd_prev = 1'b0;
  logic [29:0] cur_fields;
  int         q [$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [MD-1:0] resp(input logic [6:0] a);
    case (a)
      7'h10:   return 16'h00A5;
      7'h11:   return 16'h003C;
      default: return {9'h1DD, a};
    endcase
  endfunction

  function automatic logic [29:0] slot_fields(input int i);
    return {cmd_addr[i*7 +: 7], cmd_rw[i], cmd_stop[i], cmd_bytes[i*5 +: 5], cmd_data[i*MB +: MB]};
  endfunction

  // Outcome of one slot transaction from the table and master knobs
  task automatic model_slot(input int i);
    logic [6:0] a;
    a = cmd_addr[i*7 +: 7];
    if (no_busy) begin
      merr[i] = 1'b1;
      if (mtmo != 16'hFFFF) mtmo = mtmo + 16'd1;
    end else if (!err_addr[7] && a == err_addr[6:0]) begin
      merr[i] = 1'b1;
    end else begin
      merr[i] = 1'b0;
      if (cmd_rw[i]) begin
        mres[i] = resp(a);
        mval[i] = 1'b1;
      end
    end
  endtask

  task automatic model_pass();
    mval = '0;
    for (int i = 0; i < NC; i++) if (cmd_en[i]) model_slot(i);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) mres[i] = '0;
    mval = '0;
    merr = '0;
    mtmo = '0;
  endtask

  task automatic check_model(input string tag);
    logic [MD*NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i*MD +: MD] = mres[i];
    chk({tag, "_result"}, 64'(result), 64'(r));
    chk({tag, "_valid"}, 64'(result_valid), 64'(mval));
    chk({tag, "_error"}, 64'(slot_error), 64'(merr));
    chk({tag, "_tmo"}, 64'(timeout_cnt), 64'(mtmo));
  endtask

  // Simple master: busy rises 2 cycles after start/wakeup, then lasts busy_len
  initial begin
    int ph, mc;
    bit wk;
    ph = 0; mc = 0; wk = 1'b0;
    m_busy = 1'b0; m_error = 1'b0; m_data_in = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_busy = 1'b0;
        ph = 0;
      end else begin
        case (ph)
          0: if ((m_start && !no_busy) || m_wakeup) begin
               wk = m_wakeup; ph = 1; mc = 2;
             end
          1: begin
               mc--;
               if (mc == 0) begin
                 m_busy = 1'b1;
                 if (!wk) begin
                   m_error   = !err_addr[7] && (m_addr == err_addr[6:0]);
                   m_data_in = m_error ? 16'hDEAD : resp(m_addr);
                 end
                 mc = wk ? 10 : busy_len;
                 ph = 2;
               end
             end
          default: begin
               mc--;
               if (mc == 0) begin
                 m_busy = 1'b0;
                 ph = 0;
               end
             end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int i;
    cyc++;
    if (!rst_n) begin
      start_prev = 1'b0; wake_prev = 1'b0; pd_prev = 1'b0;
      hi_len = 0; cur_valid = 1'b0; pass_first = 1'b1;
    end else begin
      chk("start_wakeup_excl", 64'(m_start & m_wakeup), 64'(0));
      if (m_wakeup && !wake_prev) begin
        n_wake++;
        if (n_wake == 1) first_wake_cyc = cyc;
      end
      if (m_start && !start_prev) begin
        if (n_start == 0) first_start_cyc = cyc;
        n_start++;
        if (pass_first) begin
          q.delete();
          for (int k = 0; k < NC; k++) if (cmd_en[k]) q.push_back(k);
          first_start[pass_cnt % 16] = cyc;
          pass_first = 1'b0;
        end
        chk("start_has_slot", 64'(q.size() > 0), 64'(1));
        if (q.size() > 0) begin
          i = q.pop_front();
          cur_fields = slot_fields(i);
          cur_valid = 1'b1;
          chk("start_fields", 64'({m_addr, m_rw, m_stop, m_bytes, m_data_out}), 64'(cur_fields));
        end
      end
      if (m_start) hi_len++;
      else if (start_prev) begin
        if (no_busy) chk("timeout_len", 64'(hi_len), 64'(TMO));
        hi_len = 0;
      end
      if (cur_valid && (m_start || m_busy))
        chk("hold_fields", 64'({m_addr, m_rw, m_stop, m_bytes, m_data_out}), 64'(cur_fields));
      if (pass_done) begin
        chk("pass_done_pulse", 64'(pd_prev), 64'(0));
        chk("pass_all_slots", 64'(q.size()), 64'(0));
        model_pass();
        check_model("pass");
        pass_cnt++;
        pass_first = 1'b1;
      end
      start_prev = m_start;
      wake_prev  = m_wakeup;
      pd_prev    = pass_done;
    end
  end

  task automatic wait_pass(input int n, input int budget);
    int k;
    k = 0;
    while (pass_cnt < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("pass_reached", 64'(pass_cnt >= n), 64'(1));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({m_start, m_wakeup, m_addr, m_rw, m_stop, m_bytes, m_data_out, pass_done}), 64'(0));
    chk({tag, "_status"}, 64'({result, result_valid, slot_error, timeout_cnt}), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 100000", cyc);
    n_chk++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    int starts, k, pc;
    rst_n = 1'b0; enable = 1'b1; do_wakeup = 1'b1;
    cmd_en = 2'b11; cmd_rw = 2'b11; cmd_stop = 2'b01;
    cmd_addr = {7'h11, 7'h10}; cmd_bytes = {5'd2, 5'd1};
    cmd_data = {16'hBEEF, 16'h1234};
    no_busy = 1'b0; err_addr = 8'hFF; busy_len = 40;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Both read slots, wakeup precedes the first start only
    wait_pass(1, 3000);
    chk("p0_result", 64'(result), 64'(32'h003C_00A5));
    chk("p0_valid", 64'(result_valid), 64'(2'b11));
    chk("p0_wake_count", 64'(n_wake), 64'(1));
    chk("p0_wake_first", 64'(first_wake_cyc < first_start_cyc), 64'(1));
    wait_pass(2, 1000);
    chk("p1_result", 64'(result), 64'(32'h003C_00A5));

    // NACK on slot 0: old data kept, slot 1 still runs
    err_addr = 8'h10;
    wait_pass(3, 1000);
    chk("p2_result", 64'(result), 64'(32'h003C_00A5));
    chk("p2_valid", 64'(result_valid), 64'(2'b10));
    chk("p2_error", 64'(slot_error), 64'(2'b01));

    // Master never answers: start timeout on slot 0
    err_addr = 8'hFF; no_busy = 1'b1; cmd_en = 2'b01;
    wait_pass(4, 1000);
    chk("p3_tmo", 64'(timeout_cnt), 64'(1));
    chk("p3_error", 64'(slot_error), 64'(2'b01));
    chk("p3_valid", 64'(result_valid), 64'(2'b00));

    // Slot 1 becomes a write: never valid, old read data kept
    no_busy = 1'b0; cmd_en = 2'b11; cmd_rw = 2'b01;
    wait_pass(5, 1000);
    chk("p4_valid", 64'(result_valid), 64'(2'b01));
    chk("p4_result", 64'(result), 64'(32'h003C_00A5));
    chk("p4_error", 64'(slot_error), 64'(2'b00));
    wait_pass(6, 1000);
    for (int p = 2; p <= 5; p++)
      chk("pass_spacing", 64'(first_start[p] - first_start[p-1]), 64'(PER));
    chk("wake_once", 64'(n_wake), 64'(1));

    // Drop enable while slot 0 is on the bus
    starts = n_start;
    k = 0;
    while (!m_busy && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("drop_busy_seen", 64'(m_busy), 64'(1));
    enable = 1'b0;
    repeat (400) @(negedge clk);
    #1;
    chk("drop_no_pass_done", 64'(pass_cnt), 64'(6));
    chk("drop_one_slot", 64'(n_start), 64'(starts + 1));
    chk("drop_valid", 64'(result_valid), 64'(2'b01));
    mval = '0;
    model_slot(0);
    check_model("drop");

    // Reset in the middle of RUN, then restart cleanly
    pass_first = 1'b1;
    enable = 1'b1;
    k = 0;
    while (!(m_busy && !m_start && cur_valid) && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("run_seen", 64'(m_busy && !m_start), 64'(1));
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    model_reset();
    do_wakeup = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    pc = pass_cnt;
    wait_pass(pc + 1, 3000);
    chk("rst_result", 64'(result), 64'(32'h0000_00A5));
    chk("rst_valid", 64'(result_valid), 64'(2'b01));
    chk("rst_tmo", 64'(timeout_cnt), 64'(0));
    chk("rst_wake_once", 64'(n_wake), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
